router_nport: RTL and testbench

//  Parametrised 1-to-N packet router: one byte-stream ingress, NUM_PORTS output FIFOs.

---
 rtl/router_nport.sv | 226 ++++++++++++++++++++++
 tb/tb_router_nport.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_nport.sv
`default_nettype none
// ============================================================================
// Module   : router_nport
// Brief    : 1-to-N byte-stream packet router with per-port FWFT FIFOs,
//            parity check, illegal-packet drop and per-port read timeout.
// Revision : 1.0
// ============================================================================
module router_nport #(
    parameter int NUM_PORTS = 3,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int TIMEOUT   = 30
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          pkt_valid,
    output logic                          busy,
    output logic                          err,
    output logic                          drop,
    input  logic [NUM_PORTS-1:0]          read_enb,
    output logic [NUM_PORTS-1:0]          vld_out,
    output logic [NUM_PORTS*DATA_W-1:0]   data_out,
    output logic [NUM_PORTS-1:0]          soft_reset
);

    localparam int ADDR_W = $clog2(NUM_PORTS);
    localparam int LEN_W  = DATA_W - ADDR_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_PARITY  = 3'd3;
    localparam logic [2:0] S_DROP    = 3'd4;

    localparam logic [LEN_W:0] c_rem_one = (LEN_W+1)'(1);
    localparam logic [LEN_W:0] c_rem_two = (LEN_W+1)'(2);

    logic [2:0]           r_state, w_next;
    logic [ADDR_W-1:0]    r_addr;
    logic [LEN_W:0]       r_rem;
    logic [DATA_W-1:0]    r_parity, r_hdr;
    logic                 r_err, r_drop;

    logic [ADDR_W-1:0]    w_hdr_addr, w_wr_port;
    logic [LEN_W-1:0]     w_hdr_len;
    logic                 w_hdr_bad;
    logic [DATA_W-1:0]    w_wr_data;
    logic                 w_wr_req, w_load, w_dec, w_par_upd, w_err_set, w_drop_set;
    logic                 w_accept, w_busy;
    logic [NUM_PORTS-1:0] w_full, w_empty, w_flush;

    assign w_hdr_addr = data_in[ADDR_W-1:0];
    assign w_hdr_len  = data_in[DATA_W-1:ADDR_W];
    assign w_hdr_bad  = (int'(w_hdr_addr) >= NUM_PORTS) || (w_hdr_len == '0);

    // Stall uses registered FIFO counts only, so a same-cycle read never unblocks.
    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            S_WAIT:              w_busy = 1'b1;
            S_PAYLOAD, S_PARITY: w_busy = w_full[r_addr];
            default:             w_busy = 1'b0;
        endcase
    end

    assign busy     = w_busy;
    assign w_accept = pkt_valid && !w_busy;
    assign err      = r_err;
    assign drop     = r_drop;

    always_comb begin
        w_next     = r_state;
        w_wr_req   = 1'b0;
        w_wr_port  = r_addr;
        w_wr_data  = data_in;
        w_load     = 1'b0;
        w_dec      = 1'b0;
        w_par_upd  = 1'b0;
        w_err_set  = 1'b0;
        w_drop_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_wr_port = w_hdr_addr;
                if (w_accept) begin
                    w_load = 1'b1;
                    if (w_hdr_bad) begin
                        w_next = S_DROP;
                    end else if (w_empty[w_hdr_addr]) begin
                        w_wr_req = 1'b1;
                        w_next   = S_PAYLOAD;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_wr_data = r_hdr;
                if (w_flush[r_addr]) begin
                    w_next = S_DROP;
                end else if (w_empty[r_addr]) begin
                    w_wr_req = 1'b1;
                    w_next   = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_flush[r_addr]) begin
                    w_dec  = w_accept;
                    w_next = S_DROP;
                end else if (w_accept) begin
                    w_wr_req  = 1'b1;
                    w_dec     = 1'b1;
                    w_par_upd = 1'b1;
                    if (r_rem == c_rem_two) w_next = S_PARITY;
                end
            end
            S_PARITY: begin
                if (w_flush[r_addr]) begin
                    if (w_accept) begin
                        w_drop_set = 1'b1;
                        w_next     = S_IDLE;
                    end else begin
                        w_next = S_DROP;
                    end
                end else if (w_accept) begin
                    w_wr_req  = 1'b1;
                    w_err_set = (r_parity != data_in);
                    w_next    = S_IDLE;
                end
            end
            S_DROP: begin
                if (w_accept) begin
                    if (r_rem == c_rem_one) begin
                        w_drop_set = 1'b1;
                        w_next     = S_IDLE;
                    end else begin
                        w_dec = 1'b1;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // r_rem counts bytes still owed by the packet, parity byte included.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_rem    <= '0;
            r_parity <= '0;
            r_hdr    <= '0;
            r_err    <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err_set;
            r_drop  <= w_drop_set;
            if (w_load) begin
                r_addr   <= w_hdr_addr;
                r_hdr    <= data_in;
                r_parity <= data_in;
                r_rem    <= {1'b0, w_hdr_len} + c_rem_one;
            end else begin
                if (w_dec)     r_rem    <= r_rem - c_rem_one;
                if (w_par_upd) r_parity <= r_parity ^ data_in;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        localparam logic [ADDR_W-1:0] c_idx = ADDR_W'(gi);

        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0]  r_wptr, r_rptr;
        logic [CNT_W-1:0]  r_count;
        logic [TMO_W-1:0]  r_tmo;
        logic              r_soft;
        logic              w_wr, w_rd;

        assign w_empty[gi] = (r_count == '0);
        assign w_full[gi]  = (r_count == CNT_W'(DEPTH));
        // Flush on the cycle the idle counter would reach TIMEOUT.
        assign w_flush[gi] = !w_empty[gi] && !read_enb[gi] && (r_tmo == TMO_W'(TIMEOUT - 1));
        assign w_wr        = w_wr_req && (w_wr_port == c_idx);
        assign w_rd        = read_enb[gi] && !w_empty[gi];

        always_ff @(posedge clock) begin
            if (w_wr) r_mem[r_wptr] <= w_wr_data;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
                r_tmo   <= '0;
                r_soft  <= 1'b0;
            end else begin
                r_soft <= w_flush[gi];
                if (w_flush[gi]) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                    r_tmo   <= '0;
                end else begin
                    if (w_wr) r_wptr <= r_wptr + PTR_W'(1);
                    if (w_rd) r_rptr <= r_rptr + PTR_W'(1);
                    if (w_wr && !w_rd)      r_count <= r_count + CNT_W'(1);
                    else if (!w_wr && w_rd) r_count <= r_count - CNT_W'(1);
                    if (w_empty[gi] || read_enb[gi]) r_tmo <= '0;
                    else                             r_tmo <= r_tmo + TMO_W'(1);
                end
            end
        end

        assign vld_out[gi]                   = !w_empty[gi];
        assign data_out[gi*DATA_W +: DATA_W] = w_empty[gi] ? '0 : r_mem[r_rptr];
        assign soft_reset[gi]                = r_soft;
    end

endmodule
`default_nettype wire

// File: tb/tb_router_nport.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_nport
// Brief    : Directed self-checking bench for router_nport (3 ports, 8-bit).
// Revision : 1.0
// ============================================================================
module tb_router_nport;

    localparam int NP = 3;
    localparam int DW = 8;

    logic             clock = 1'b0;
    logic             reset;
    logic [DW-1:0]    data_in;
    logic             pkt_valid;
    logic             busy, err, drop;
    logic [NP-1:0]    read_enb;
    logic [NP-1:0]    vld_out;
    logic [NP*DW-1:0] data_out;
    logic [NP-1:0]    soft_reset;

    int checks   = 0;
    int failures = 0;

    router_nport #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(16), .TIMEOUT(30)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .pkt_valid(pkt_valid),
        .busy(busy), .err(err), .drop(drop), .read_enb(read_enb),
        .vld_out(vld_out), .data_out(data_out), .soft_reset(soft_reset)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the byte is accepted.
    task automatic send_byte(input logic [7:0] b, output int waits);
        data_in   = b;
        pkt_valid = 1'b1;
        waits     = 0;
        while (busy && waits < 200) begin
            @(negedge clock);
            waits++;
        end
        @(negedge clock);
        pkt_valid = 1'b0;
    endtask

    task automatic read_byte(input int p, output logic v, output logic [7:0] d);
        v           = vld_out[p];
        d           = data_out[p*8 +: 8];
        read_enb[p] = 1'b1;
        @(negedge clock);
        read_enb = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pkt_valid = 1'b0; data_in = '0; read_enb = '0;
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, err, drop, vld_out, data_out, soft_reset} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b err=%b drop=%b vld=%b data=%h sr=%b, want all 0",
                     busy, err, drop, vld_out, data_out, soft_reset);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || vld_out !== 3'b000) begin
            failures++;
            $display("FAIL reset_release: got busy=%b vld=%b, want 0/000", busy, vld_out);
        end
    endtask

    task automatic test_route();
        logic [7:0] pkt [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        int w, total;
        logic v;
        logic [7:0] d;
        total = 0;
        for (int i = 0; i < 5; i++) begin
            send_byte(pkt[i], w);
            total += w;
        end
        checks++;
        if (total !== 0) begin
            failures++;
            $display("FAIL route_busy: got %0d stall cycles, want 0", total);
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL route_err: got err=%b, want 0", err);
        end
        checks++;
        if (vld_out !== 3'b010) begin
            failures++;
            $display("FAIL route_vld: got %b, want 010", vld_out);
        end
        for (int i = 0; i < 5; i++) begin
            read_byte(1, v, d);
            checks++;
            if (v !== 1'b1 || d !== pkt[i]) begin
                failures++;
                $display("FAIL route_read%0d: got vld=%b data=%h, want 1/%h", i, v, d, pkt[i]);
            end
        end
        checks++;
        if (vld_out !== 3'b000 || data_out !== '0) begin
            failures++;
            $display("FAIL route_drained: got vld=%b data=%h, want 000/0", vld_out, data_out);
        end
    endtask

    task automatic test_parity_err();
        logic [7:0] pkt [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
        int w;
        logic v;
        logic [7:0] d;
        for (int i = 0; i < 4; i++) send_byte(pkt[i], w);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL perr_early: got err=%b before parity, want 0", err);
        end
        send_byte(pkt[4], w);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL perr_pulse: got err=%b after parity accept, want 1", err);
        end
        @(negedge clock);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL perr_width: got err=%b second cycle, want 0", err);
        end
        for (int i = 0; i < 5; i++) begin
            read_byte(1, v, d);
            checks++;
            if (v !== 1'b1 || d !== pkt[i]) begin
                failures++;
                $display("FAIL perr_read%0d: got vld=%b data=%h, want 1/%h", i, v, d, pkt[i]);
            end
        end
    endtask

    task automatic test_illegal_addr();
        logic [7:0] pkt [4] = '{8'h0B, 8'h01, 8'h02, 8'h03};
        int w, total;
        total = 0;
        for (int i = 0; i < 3; i++) begin
            send_byte(pkt[i], w);
            total += w;
        end
        checks++;
        if (drop !== 1'b0) begin
            failures++;
            $display("FAIL illegal_drop_early: got drop=%b, want 0", drop);
        end
        send_byte(pkt[3], w);
        total += w;
        checks++;
        if (drop !== 1'b1) begin
            failures++;
            $display("FAIL illegal_drop: got drop=%b after last byte, want 1", drop);
        end
        checks++;
        if (total !== 0 || vld_out !== 3'b000) begin
            failures++;
            $display("FAIL illegal_state: got stalls=%0d vld=%b, want 0/000", total, vld_out);
        end
        @(negedge clock);
        checks++;
        if (drop !== 1'b0) begin
            failures++;
            $display("FAIL illegal_drop_width: got drop=%b, want 0", drop);
        end
    endtask

    task automatic test_timeout();
        int w, total, cyc;
        total = 0;
        send_byte(8'h50, w);
        checks++;
        if (vld_out !== 3'b001) begin
            failures++;
            $display("FAIL tmo_vld: got %b, want 001", vld_out);
        end
        for (int i = 1; i <= 15; i++) begin
            send_byte(8'(i), w);
            total += w;
        end
        checks++;
        if (total !== 0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL tmo_full: got stalls=%0d busy=%b, want 0/1", total, busy);
        end
        data_in   = 8'd16;
        pkt_valid = 1'b1;
        cyc       = 0;
        while (soft_reset !== 3'b001 && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (cyc !== 15) begin
            failures++;
            $display("FAIL tmo_latency: got soft_reset after %0d cycles, want 15", cyc);
        end
        checks++;
        if (vld_out !== 3'b000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL tmo_flush: got vld=%b busy=%b, want 000/0", vld_out, busy);
        end
        @(negedge clock);
        pkt_valid = 1'b0;
        checks++;
        if (soft_reset !== 3'b000 || vld_out !== 3'b000) begin
            failures++;
            $display("FAIL tmo_pulse: got sr=%b vld=%b, want 000/000", soft_reset, vld_out);
        end
        for (int i = 17; i <= 20; i++) send_byte(8'(i), w);
        checks++;
        if (drop !== 1'b0) begin
            failures++;
            $display("FAIL tmo_drop_early: got drop=%b, want 0", drop);
        end
        send_byte(8'h00, w);
        checks++;
        if (drop !== 1'b1 || vld_out !== 3'b000) begin
            failures++;
            $display("FAIL tmo_drop: got drop=%b vld=%b, want 1/000", drop, vld_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pa [4] = '{8'h0A, 8'hAA, 8'hBB, 8'h1B};
        logic [7:0] pb [3] = '{8'h06, 8'h5C, 8'h5A};
        int w, total, low;
        logic v;
        logic [7:0] d;
        total = 0;
        low   = 0;
        for (int i = 0; i < 4; i++) begin
            send_byte(pa[i], w);
            total += w;
        end
        send_byte(pb[0], w);
        total += w;
        checks++;
        if (total !== 0 || busy !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_wait: got stalls=%0d busy=%b err=%b, want 0/1/0", total, busy, err);
        end
        for (int i = 0; i < 4; i++) begin
            repeat (3) begin
                @(negedge clock);
                if (busy !== 1'b1) low++;
            end
            read_byte(2, v, d);
            checks++;
            if (v !== 1'b1 || d !== pa[i]) begin
                failures++;
                $display("FAIL b2b_read_a%0d: got vld=%b data=%h, want 1/%h", i, v, d, pa[i]);
            end
        end
        checks++;
        if (low !== 0 || busy !== 1'b1 || vld_out[2] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_empty_cycle: got busy_low=%0d busy=%b vld2=%b, want 0/1/0",
                     low, busy, vld_out[2]);
        end
        @(negedge clock);
        checks++;
        if (vld_out[2] !== 1'b1 || data_out[23:16] !== 8'h06 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_hdr_write: got vld2=%b data=%h busy=%b, want 1/06/0",
                     vld_out[2], data_out[23:16], busy);
        end
        for (int i = 1; i < 3; i++) send_byte(pb[i], w);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL b2b_err: got err=%b, want 0", err);
        end
        for (int i = 0; i < 3; i++) begin
            read_byte(2, v, d);
            checks++;
            if (v !== 1'b1 || d !== pb[i]) begin
                failures++;
                $display("FAIL b2b_read_b%0d: got vld=%b data=%h, want 1/%h", i, v, d, pb[i]);
            end
        end
        checks++;
        if (vld_out !== 3'b000) begin
            failures++;
            $display("FAIL b2b_drained: got vld=%b, want 000", vld_out);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] pkt [3] = '{8'h04, 8'h77, 8'h73};
        int w;
        logic v;
        logic [7:0] d;
        send_byte(8'h0D, w);
        send_byte(8'h11, w);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({busy, err, drop, vld_out, data_out, soft_reset} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs: got busy=%b err=%b drop=%b vld=%b data=%h sr=%b, want all 0",
                     busy, err, drop, vld_out, data_out, soft_reset);
        end
        reset = 1'b0;
        @(negedge clock);
        for (int i = 0; i < 3; i++) send_byte(pkt[i], w);
        checks++;
        if (err !== 1'b0 || vld_out !== 3'b001) begin
            failures++;
            $display("FAIL midrst_route: got err=%b vld=%b, want 0/001", err, vld_out);
        end
        for (int i = 0; i < 3; i++) begin
            read_byte(0, v, d);
            checks++;
            if (v !== 1'b1 || d !== pkt[i]) begin
                failures++;
                $display("FAIL midrst_read%0d: got vld=%b data=%h, want 1/%h", i, v, d, pkt[i]);
            end
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_route();
        test_parity_err();
        test_illegal_addr();
        test_timeout();
        test_back_to_back();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
